// File: rtl/rv_dp.sv
// Multicycle RISC-V datapath: PC/PCC/IR/MDR/ALUOUT state, 32x32 register file,
// immediate generator, operand muxes and ALU, sequenced by an external control plane.
module rv_dp #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] F8_CONST = 32'h0000_00F8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcsourse,
    input  logic        pcwrite,
    input  logic        pccen,
    input  logic        irwrite,
    input  logic [1:0]  wbsel,
    input  logic        regwen,
    input  logic [1:0]  immsel,
    input  logic [1:0]  asel,
    input  logic [1:0]  bsel,
    input  logic [3:0]  alusel,
    input  logic        mdrwrite,
    output logic [31:0] instr,
    output logic        zero,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata
);

    localparam logic [1:0] WB_PC     = 2'd0;
    localparam logic [1:0] WB_ALUOUT = 2'd1;
    localparam logic [1:0] WB_MDR    = 2'd2;
    localparam logic [1:0] IMM_B     = 2'd0;
    localparam logic [1:0] IMM_L     = 2'd1;
    localparam logic [1:0] IMM_S     = 2'd2;
    localparam logic [1:0] ALUA_REG  = 2'd0;
    localparam logic [1:0] ALUA_PCC  = 2'd1;
    localparam logic [1:0] ALUA_OUT  = 2'd2;
    localparam logic [1:0] ALUB_REG  = 2'd0;
    localparam logic [1:0] ALUB_IMM  = 2'd1;
    localparam logic [1:0] ALUB_F8   = 2'd2;

    logic [31:0] pc_q, pc_d;
    logic [31:0] pcc_q, ir_q, mdr_q, aluout_q;
    logic [31:0] regs_q [32];

    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_val, rs2_val, imm, alu_a, alu_b, alu_res, wb_data;
    logic [4:0]  shamt;

    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign rd  = ir_q[11:7];

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];

    always_comb begin
        imm = '0;
        case (immsel)
            IMM_B:   imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            IMM_L:   imm = {{20{ir_q[31]}}, ir_q[31:20]};
            IMM_S:   imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            default: imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
        endcase
    end

    // Reserved select code 3 on either operand mux drives zero.
    always_comb begin
        alu_a = '0;
        case (asel)
            ALUA_REG: alu_a = rs1_val;
            ALUA_PCC: alu_a = pcc_q;
            ALUA_OUT: alu_a = aluout_q;
            default:  alu_a = '0;
        endcase
        alu_b = '0;
        case (bsel)
            ALUB_REG: alu_b = rs2_val;
            ALUB_IMM: alu_b = imm;
            ALUB_F8:  alu_b = F8_CONST;
            default:  alu_b = '0;
        endcase
    end

    assign shamt = alu_b[4:0];

    always_comb begin
        alu_res = '0;
        casez (alusel)
            4'b0000: alu_res = alu_a + alu_b;
            4'b0001: alu_res = alu_a - alu_b;
            4'b001?: alu_res = alu_a << shamt;
            4'b010?: alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b011?: alu_res = {31'd0, alu_a < alu_b};
            4'b100?: alu_res = alu_a ^ alu_b;
            4'b1010: alu_res = alu_a >> shamt;
            4'b1011: alu_res = $signed(alu_a) >>> shamt;
            4'b110?: alu_res = alu_a | alu_b;
            default: alu_res = alu_a & alu_b;
        endcase
    end

    assign zero = (alu_res == 32'd0);

    // WB_PC returns PC, which already holds the incremented return address.
    always_comb begin
        wb_data = '0;
        case (wbsel)
            WB_PC:     wb_data = pc_q;
            WB_ALUOUT: wb_data = aluout_q;
            WB_MDR:    wb_data = mdr_q;
            default:   wb_data = '0;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (pcwrite) pc_d = pcsourse ? alu_res : pc_q + 32'd4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            pcc_q    <= '0;
            ir_q     <= '0;
            mdr_q    <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            aluout_q <= alu_res;
            if (pccen)    pcc_q <= pc_q;
            if (irwrite)  ir_q  <= imem_rdata;
            if (mdrwrite) mdr_q <= dmem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (regwen && rd != 5'd0) begin
            regs_q[rd] <= wb_data;
        end
    end

    assign instr      = ir_q;
    assign imem_addr  = pc_q;
    assign dmem_addr  = aluout_q;
    assign dmem_wdata = rs2_val;

endmodule

// File: tb/tb_rv_dp.sv
// Bench for rv_dp: directed datapath sequences plus a random control phase,
// all checked against an instruction-level model of the datapath state.
module tb_rv_dp;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite;
    logic [1:0]  wbsel, immsel, asel, bsel;
    logic [3:0]  alusel;
    logic [31:0] instr, imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic        zero;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];

    logic [31:0] m_pc, m_pcc, m_ir, m_mdr, m_alu_q;
    logic [31:0] m_regs [32];

    rv_dp dut (
        .clk(clk), .rst(rst), .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen),
        .irwrite(irwrite), .wbsel(wbsel), .regwen(regwen), .immsel(immsel),
        .asel(asel), .bsel(bsel), .alusel(alusel), .mdrwrite(mdrwrite),
        .instr(instr), .zero(zero), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_reg(input logic [4:0] i);
        return (i == 5'd0) ? 32'd0 : m_regs[i];
    endfunction

    // Immediates as signed integers: field value minus 2^width when the sign bit is set.
    function automatic logic [31:0] m_imm(input logic [1:0] sel, input logic [31:0] ir);
        int v;
        case (sel)
            2'd0: begin v = int'({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}); if (ir[31]) v -= 8192; end
            2'd1: begin v = int'(ir[31:20]); if (ir[31]) v -= 4096; end
            2'd2: begin v = int'({ir[31:25], ir[11:7]}); if (ir[31]) v -= 4096; end
            default: begin v = int'({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}); if (ir[31]) v -= 2097152; end
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        int sh;
        sa = a; sb = b; sh = int'(b[4:0]);
        case (op)
            4'd0:        return a + b;
            4'd1:        return a - b;
            4'd2, 4'd3:  return a << sh;
            4'd4, 4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd6, 4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8, 4'd9:  return a ^ b;
            4'd10:       return a >> sh;
            4'd11:       return sa >>> sh;
            4'd12, 4'd13: return a | b;
            default:     return a & b;
        endcase
    endfunction

    function automatic logic [31:0] m_alu_now();
        logic [31:0] a, b;
        case (asel)
            2'd0: a = m_reg(m_ir[19:15]);
            2'd1: a = m_pcc;
            2'd2: a = m_alu_q;
            default: a = 32'd0;
        endcase
        case (bsel)
            2'd0: b = m_reg(m_ir[24:20]);
            2'd1: b = m_imm(immsel, m_ir);
            2'd2: b = 32'h0000_00F8;
            default: b = 32'd0;
        endcase
        return m_alu(alusel, a, b);
    endfunction

    task automatic model_reset();
        m_pc = 32'd0; m_pcc = '0; m_ir = '0; m_mdr = '0; m_alu_q = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("instr", instr, m_ir);
        chk("imem_addr", imem_addr, m_pc);
        chk("dmem_addr", dmem_addr, m_alu_q);
        chk("dmem_wdata", dmem_wdata, m_reg(m_ir[24:20]));
        chk("zero", {31'd0, zero}, {31'd0, m_alu_now() == 32'd0});
    endtask

    task automatic idle();
        pcsourse = 0; pcwrite = 0; pccen = 0; irwrite = 0; regwen = 0; mdrwrite = 0;
        wbsel = 0; immsel = 0; asel = 0; bsel = 0; alusel = 0;
    endtask

    // One clock: predict from pre-edge state and inputs, commit at the edge, then compare.
    task automatic tick();
        logic [31:0] res, wb, n_pc;
        res = m_alu_now();
        case (wbsel)
            2'd0: wb = m_pc;
            2'd1: wb = m_alu_q;
            2'd2: wb = m_mdr;
            default: wb = 32'd0;
        endcase
        n_pc = pcwrite ? (pcsourse ? res : m_pc + 32'd4) : m_pc;
        @(posedge clk);
        if (regwen && m_ir[11:7] != 5'd0) m_regs[m_ir[11:7]] = wb;
        if (pccen) m_pcc = m_pc;
        m_pc = n_pc;
        if (irwrite) m_ir = imem_rdata;
        if (mdrwrite) m_mdr = dmem_rdata;
        m_alu_q = res;
        #2;
        check_all();
    endtask

    task automatic set_ir(input logic [31:0] w);
        idle(); imem_rdata = w; irwrite = 1; tick(); idle();
    endtask

    task automatic set_reg(input logic [4:0] idx, input logic [31:0] val);
        idle();
        imem_rdata = {20'd0, idx, 7'd0}; irwrite = 1;
        dmem_rdata = val; mdrwrite = 1;
        tick();
        idle(); wbsel = 2'd2; regwen = 1; tick(); idle();
    endtask

    task automatic read_reg(input logic [4:0] idx, input logic [31:0] exp);
        set_ir({7'd0, idx, 20'd0});
        #1;
        chk("reg_readback", dmem_wdata, exp);
    endtask

    initial begin
        rst = 1; idle(); imem_rdata = '0; dmem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_instr", instr, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        rst = 0;
        #1;

        // Fetch addi x1,x0,5
        imem_rdata = 32'h0050_0093; pccen = 1; pcwrite = 1; irwrite = 1;
        tick(); idle();
        chk("fetch_instr", instr, 32'h0050_0093);
        chk("fetch_pc", imem_addr, 32'd4);
        asel = 2'd1; bsel = 2'd3; #1;
        chk("fetch_pcc_zero", {31'd0, zero}, 32'd1);

        // ADDI execute then writeback
        idle(); bsel = 2'd1; immsel = 2'd1; tick();
        chk("addi_aluout", dmem_addr, 32'd5);
        idle(); wbsel = 2'd1; regwen = 1; tick(); idle();
        read_reg(5'd1, 32'd5);

        // x0 protection
        set_ir(32'h0070_0013);
        bsel = 2'd1; immsel = 2'd1; tick();
        chk("x0_aluout", dmem_addr, 32'd7);
        idle(); wbsel = 2'd1; regwen = 1; tick(); idle();
        bsel = 2'd3; #1;
        chk("x0_rs1_zero", {31'd0, zero}, 32'd1);
        read_reg(5'd0, 32'd0);

        // BEQ not taken then taken, PCC=16
        set_reg(5'd1, 32'd9); set_reg(5'd2, 32'd8);
        set_ir(32'h0100_0013);
        pcwrite = 1; pcsourse = 1; asel = 2'd3; bsel = 2'd1; immsel = 2'd1; tick();
        idle(); pccen = 1; tick(); idle();
        chk("beq_pc16", imem_addr, 32'd16);
        set_ir(32'hFE20_8CE3);
        asel = 2'd1; bsel = 2'd1; immsel = 2'd0; tick(); idle();
        chk("beq_nt_target", dmem_addr, 32'd8);
        alusel = 4'b0001; #1;
        chk("beq_nt_zero", {31'd0, zero}, 32'd0);
        tick(); idle();
        chk("beq_nt_pc", imem_addr, 32'd16);
        set_reg(5'd2, 32'd9);
        set_ir(32'hFE20_8CE3);
        asel = 2'd1; bsel = 2'd1; immsel = 2'd0; tick(); idle();
        chk("beq_t_target", dmem_addr, 32'd8);
        alusel = 4'b0001; pcwrite = 1; pcsourse = 1; #1;
        chk("beq_t_zero", {31'd0, zero}, 32'd1);
        tick(); idle();
        chk("beq_t_pc", imem_addr, 32'd0);

        // sw x2,4(x1) and lw x3,4(x1)
        set_reg(5'd1, 32'h100); set_reg(5'd2, 32'hDEAD_BEEF);
        set_ir(32'h0020_A223);
        bsel = 2'd1; immsel = 2'd2; tick(); idle();
        chk("sw_addr", dmem_addr, 32'h104);
        chk("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
        set_ir(32'h0040_A183);
        bsel = 2'd1; immsel = 2'd1; tick(); idle();
        chk("lw_addr", dmem_addr, 32'h104);
        dmem_rdata = 32'h1234; mdrwrite = 1; tick(); idle();
        wbsel = 2'd2; regwen = 1; tick(); idle();
        read_reg(5'd3, 32'h1234);

        // ALU corners
        set_reg(5'd1, 32'h8000_0000); set_reg(5'd2, 32'd4);
        set_ir(32'h0020_8000);
        alusel = 4'b1011; tick(); idle();
        chk("sra", dmem_addr, 32'hF800_0000);
        set_reg(5'd1, 32'hFFFF_FFFF); set_reg(5'd2, 32'd1);
        set_ir(32'h0020_8000);
        alusel = 4'b0100; tick(); idle();
        chk("slt", dmem_addr, 32'd1);
        alusel = 4'b0110; #1;
        chk("sltu_zero", {31'd0, zero}, 32'd1);
        tick(); idle();
        chk("sltu", dmem_addr, 32'd0);
        #1;
        chk("add_wrap_zero", {31'd0, zero}, 32'd1);
        tick(); idle();
        chk("add_wrap", dmem_addr, 32'd0);
        set_ir(32'h00F0_0013);
        asel = 2'd3; bsel = 2'd1; immsel = 2'd1; tick(); idle();
        chk("aluout_0f", dmem_addr, 32'h0F);
        asel = 2'd2; bsel = 2'd2; alusel = 4'b1000; tick(); idle();
        chk("xor_f8", dmem_addr, 32'hF7);

        // JAL-style: rd gets old PC while PC loads the ALU target
        pcwrite = 1; tick(); tick(); idle();
        chk("pc_inc", imem_addr, 32'd8);
        set_ir(32'h0000_0280);
        regwen = 1; wbsel = 2'd0; pcwrite = 1; pcsourse = 1; asel = 2'd3; bsel = 2'd2;
        tick(); idle();
        chk("jal_pc", imem_addr, 32'hF8);
        read_reg(5'd5, 32'd8);

        // Random control sequences against the model
        for (int n = 0; n < 400; n++) begin
            pcsourse = 1'($urandom); pcwrite = 1'($urandom); pccen = 1'($urandom);
            irwrite = 1'($urandom); regwen = 1'($urandom); mdrwrite = 1'($urandom);
            wbsel = 2'($urandom); immsel = 2'($urandom); asel = 2'($urandom);
            bsel = 2'($urandom); alusel = 4'($urandom_range(0, 15));
            imem_rdata = $urandom; dmem_rdata = $urandom;
            #1;
            tick();
        end
        idle();
        for (int i = 1; i < 32; i++) exp_q.push_back(m_regs[i]);
        for (int i = 1; i < 32; i++) read_reg(5'(i), exp_q.pop_front());

        // Async reset mid-instruction with PC=0x40
        set_ir(32'h0400_0013);
        pcwrite = 1; pcsourse = 1; asel = 2'd3; bsel = 2'd1; immsel = 2'd1; tick(); idle();
        chk("pc_40", imem_addr, 32'h40);
        @(negedge clk);
        rst = 1;
        #1;
        chk("arst_pc", imem_addr, 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_dmem_addr", dmem_addr, 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst = 0;
        for (int i = 1; i < 32; i++) read_reg(5'(i), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_dp.md
Name: rv_dp

Overview:
- Multicycle RISC-V datapath: PC, PCC (PC of the current instruction), IR, MDR, ALUOUT, 32x32 register file, immediate generator, operand muxes and ALU.
- Driven cycle-by-cycle by the control plane. Returns instr and zero to it.
- Harvard memory view: combinational-read instruction and data memories outside the block; writes are synchronous in the memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- F8_CONST, 32'h0000_00F8, constant driven on ALU operand B when bsel=ALUB_F8.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- pcsourse  in  1  PC next-value select: 0=PC_INC (PC+4), 1=PC_ALU (ALU result).
- pcwrite  in  1  PC load enable.
- pccen  in  1  PCC load enable (PCC<=PC).
- irwrite  in  1  IR load enable (IR<=imem_rdata).
- wbsel  in  2  writeback select: 0=WB_PC, 1=WB_ALUOUT, 2=WB_MDR, 3=zero.
- regwen  in  1  register-file write enable.
- immsel  in  2  immediate select: 0=IMM_B, 1=IMM_L (I-type), 2=IMM_S, 3=IMM_J.
- asel  in  2  ALU A select: 0=ALUA_REG (rs1), 1=ALUA_PCC, 2=ALUA_ALUOUT, 3=zero.
- bsel  in  2  ALU B select: 0=ALUB_REG (rs2), 1=ALUB_IMM, 2=ALUB_F8, 3=zero.
- alusel  in  4  ALU op {funct3,instr[30]}.
- mdrwrite  in  1  MDR load enable (MDR<=dmem_rdata).
- instr  out  32  IR contents.
- zero  out  1  combinational: ALU result == 0.
- imem_addr  out  32  = PC.
- imem_rdata  in  32  instruction word at imem_addr.
- dmem_addr  out  32  = ALUOUT.
- dmem_wdata  out  32  = regfile[rs2].
- dmem_rdata  in  32  data word at dmem_addr.

Behaviour:
- Reset (async, immediate on rst rise):
  - PC=RESET_PC; PCC=0; IR=0; MDR=0; ALUOUT=0; all 32 registers=0.
  - Outputs follow: instr=0, imem_addr=RESET_PC, dmem_addr=0.
  - A reset mid-instruction discards all in-flight state.
- Fields from IR:
  - rs1=IR[19:15], rs2=IR[24:20], rd=IR[11:7].
- Register file:
  - Two combinational reads; one synchronous write on posedge when regwen=1.
  - x0 reads 0 always; writes to rd=0 are ignored.
  - A read of the register being written in the same cycle returns the old value.
- Immediates, all sign-extended from IR[31]:
  - IMM_L = IR[31:20].
  - IMM_S = {IR[31:25],IR[11:7]}.
  - IMM_B = {IR[31],IR[7],IR[30:25],IR[11:8],0}.
  - IMM_J = {IR[31],IR[19:12],IR[20],IR[30:21],0}.
- ALU (combinational, 32-bit, wrap-around, no flags except zero):
  - 0000 ADD; 0001 SUB; 0010/0011 SLL.
  - 0100/0101 SLT (signed); 0110/0111 SLTU.
  - 1000/1001 XOR; 1010 SRL; 1011 SRA.
  - 1100/1101 OR; 1110/1111 AND.
  - Shift amount is B[4:0].
- ALUOUT <= ALU result every clock, unconditionally.
- PC: when pcwrite=1, PC <= (pcsourse ? ALU result : PC+4). PC+4 wraps modulo 2^32.
- PCC <= PC when pccen=1.
- IR <= imem_rdata when irwrite=1.
- MDR <= dmem_rdata when mdrwrite=1.
- Writeback data mux:
  - WB_PC selects PC, the already-incremented return address.
  - WB_ALUOUT selects the registered ALUOUT, not the live ALU result.
  - WB_MDR selects MDR.
- Simultaneous enables in one cycle: all loads take their pre-edge sources.
  - Example: pcwrite+pccen together → PCC gets the old PC.
  - Example: JAL regwen+pcwrite together → rd gets the old PC (PC+4), and PC gets the ALU target.
- Reserved select codes (wbsel/asel/bsel=3) drive zero.
- Latency:
  - Register/PC/IR/MDR updates are visible the cycle after the enabling edge.
  - zero, dmem_wdata and imem_addr are combinational from current state.

Test Plan:
- Reset then fetch: rst pulse; imem_rdata=32'h00500093 (addi x1,x0,5); pccen/pcwrite/irwrite for 1 cycle → instr=32'h00500093, PC=4, PCC=0.
- ADDI path: then asel=REG, bsel=IMM, immsel=IMM_L, alusel=0000 one cycle; wbsel=ALUOUT, regwen next cycle → x1=5.
- x0 protection: instr with rd=0, regwen=1, ALUOUT=7 → x0 still reads 0 via rs1=0.
- BEQ: x1=x2=9, IR=beq offset −8, PCC=16.
  - DECODE cycle with asel=PCC, bsel=IMM, immsel=IMM_B → ALUOUT=8.
  - Next cycle with SUB, zero=1, pcwrite, pcsourse=ALU → PC=0.
  - Repeat with x2=8 → zero=0, PC unchanged.
- Load/store: regs x1=0x100, x2=0xDEADBEEF.
  - sw offset 4 → dmem_addr=0x104, dmem_wdata=0xDEADBEEF.
  - lw: mdrwrite with dmem_rdata=0x1234 then WB_MDR → rd=0x1234.
- ALU corners:
  - SRA 0x80000000>>4 = 0xF8000000.
  - SLT(−1,1)=1; SLTU(−1,1)=0.
  - ADD 0xFFFFFFFF+1 = 0 with zero=1.
  - XOR ALUOUT with F8 (ALUOUT=0x0F) = 0xF7.
- Async reset mid-instruction: assert rst between clk edges with PC=0x40 → PC=RESET_PC immediately, registers cleared.
